// File: rtl/fifo_cmd_reader.sv
// Read-side FIFO consumer: paced dequeue into a one-entry holding register, framed into header+payload packets.
// Optional statistics counters are enabled with `define FIFO_CMD_READER_STATS_EN.
module fifo_cmd_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] fifo_q_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_deq_o,
  output logic [DATA_WIDTH-1:0] cmd_data_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic                  cmd_first_o,
  output logic                  cmd_last_o,
  output logic                  busy_o
`ifdef FIFO_CMD_READER_STATS_EN
  ,
  output logic [31:0]           stat_words_o,
  output logic [31:0]           stat_pkts_o,
  output logic [31:0]           stat_stall_o
`endif
);

  localparam logic [0:0] F_READY  = 1'b0;
  localparam logic [0:0] F_SETTLE = 1'b1;
  localparam logic [0:0] R_HDR    = 1'b0;
  localparam logic [0:0] R_PAY    = 1'b1;

  logic [0:0]            fetch_q, fetch_d;
  logic [0:0]            frame_q, frame_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  hs, capture;

  assign hs      = valid_q && cmd_ready_i;
  assign capture = !rst_i && (fetch_q == F_READY) && !fifo_empty_i && (!valid_q || cmd_ready_i);

  always_comb begin
    fetch_d = (fetch_q == F_READY && capture) ? F_SETTLE : F_READY;
  end

  always_comb begin
    frame_d = frame_q;
    cnt_d   = cnt_q;
    if (hs) begin
      if (frame_q == R_HDR) begin
        if (data_q[LEN_WIDTH-1:0] != '0) begin
          frame_d = R_PAY;
          cnt_d   = data_q[LEN_WIDTH-1:0];
        end
      end else begin
        cnt_d = cnt_q - LEN_WIDTH'(1);
        if (cnt_q == LEN_WIDTH'(1)) frame_d = R_HDR;
      end
    end
  end

  // Flags of a newly captured word follow the framing state after any same-cycle handshake.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    if (capture) begin
      data_d  = fifo_q_i;
      valid_d = 1'b1;
      first_d = (frame_d == R_HDR);
      last_d  = (frame_d == R_HDR) ? (fifo_q_i[LEN_WIDTH-1:0] == '0) : (cnt_d == LEN_WIDTH'(1));
    end else if (hs) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      fetch_q <= F_READY;
      frame_q <= R_HDR;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      fetch_q <= fetch_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign fifo_deq_o  = capture;
  assign cmd_data_o  = data_q;
  assign cmd_valid_o = valid_q;
  assign cmd_first_o = first_q;
  assign cmd_last_o  = last_q;
  assign busy_o      = (frame_q == R_PAY);

`ifdef FIFO_CMD_READER_STATS_EN
  logic [31:0] words_q, pkts_q, stall_q;

  // All counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      words_q <= '0;
      pkts_q  <= '0;
      stall_q <= '0;
    end else begin
      if (capture && words_q != '1) words_q <= words_q + 32'd1;
      if (hs && last_q && pkts_q != '1) pkts_q <= pkts_q + 32'd1;
      if (valid_q && !cmd_ready_i && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_words_o = words_q;
  assign stat_pkts_o  = pkts_q;
  assign stat_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_fifo_cmd_reader.sv
// Bench for fifo_cmd_reader: FIFO model with settle-cycle read data, packet-framing reference model, per-cycle checks.
module tb_fifo_cmd_reader;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] fifo_q_i = 32'hDEAD_BEEF;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_deq_o;
  logic [31:0] cmd_data_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1'b1;
  logic        cmd_first_o;
  logic        cmd_last_o;
  logic        busy_o;
`ifdef FIFO_CMD_READER_STATS_EN
  logic [31:0] stat_words_o, stat_pkts_o, stat_stall_o;
`endif

  always #5 clk = ~clk;

  fifo_cmd_reader #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_i(rst_i),
    .fifo_q_i(fifo_q_i), .fifo_empty_i(fifo_empty_i), .fifo_deq_o(fifo_deq_o),
    .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_first_o(cmd_first_o), .cmd_last_o(cmd_last_o), .busy_o(busy_o)
`ifdef FIFO_CMD_READER_STATS_EN
    , .stat_words_o(stat_words_o), .stat_pkts_o(stat_pkts_o), .stat_stall_o(stat_stall_o)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] fifo_m[$];
  logic [31:0] exp_q[$];
  logic [31:0] log_data[$];
  logic        log_first[$];
  logic        log_last[$];
  logic        pop_pend = 1'b0;
  logic        rst_req = 1'b1;
  logic        ready_toggle = 1'b0;
  logic        rdy_phase = 1'b0;
  logic        prev_deq = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_first = 1'b0;
  logic        prev_last = 1'b0;
  int          rem = 0;
  int          hs_cnt = 0;
  int          deq_cnt = 0;
  int          stall_cnt = 0;
  int          pkt_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [31:0] w;
    logic ef, el;
    @(negedge clk);
    rst_i = rst_req;
    if (pop_pend) void'(fifo_m.pop_front());
    fifo_empty_i = (fifo_m.size() == 0);
    fifo_q_i = (pop_pend || fifo_m.size() == 0) ? 32'hDEAD_BEEF : fifo_m[0];
    pop_pend = 1'b0;
    if (ready_toggle) begin
      cmd_ready_i = rdy_phase;
      rdy_phase = ~rdy_phase;
    end else begin
      cmd_ready_i = 1'b1;
    end
    #1;
    if (rst_i) begin
      chk("deq_in_reset", 32'(fifo_deq_o), 32'd0);
      exp_q.delete();
      rem = 0;
      prev_stall = 1'b0;
      prev_deq = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 32'(cmd_valid_o), 32'd1);
        chk("stall_data_hold", cmd_data_o, prev_data);
        chk("stall_first_hold", 32'(cmd_first_o), 32'(prev_first));
        chk("stall_last_hold", 32'(cmd_last_o), 32'(prev_last));
      end
      chk("busy", 32'(busy_o), 32'(rem != 0));
      if (cmd_valid_o && cmd_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", cmd_data_o, 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          if (rem == 0) begin
            ef = 1'b1;
            el = (w[15:0] == 16'd0);
            rem = int'(w[15:0]);
          end else begin
            ef = 1'b0;
            el = (rem == 1);
            rem--;
          end
          chk("out_data", cmd_data_o, w);
          chk("out_first", 32'(cmd_first_o), 32'(ef));
          chk("out_last", 32'(cmd_last_o), 32'(el));
        end
        log_data.push_back(cmd_data_o);
        log_first.push_back(cmd_first_o);
        log_last.push_back(cmd_last_o);
        hs_cnt++;
        if (cmd_last_o) pkt_cnt++;
      end
      if (fifo_deq_o) begin
        chk("deq_back_to_back", 32'(prev_deq), 32'd0);
        chk("deq_when_empty", 32'(fifo_empty_i), 32'd0);
        if (fifo_m.size() != 0) exp_q.push_back(fifo_m[0]);
        deq_cnt++;
        pop_pend = 1'b1;
      end
      prev_deq = fifo_deq_o;
      prev_stall = cmd_valid_o && !cmd_ready_i;
      if (prev_stall) stall_cnt++;
      prev_data = cmd_data_o;
      prev_first = cmd_first_o;
      prev_last = cmd_last_o;
    end
  endtask

  task automatic do_reset();
    fifo_m.delete();
    ready_toggle = 1'b0;
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    hs_cnt = 0; deq_cnt = 0; stall_cnt = 0; pkt_cnt = 0;
    log_data.delete(); log_first.delete(); log_last.delete();
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (hs_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    chk(name, 32'(hs_cnt), 32'(target));
  endtask

  task automatic chk_log(input int idx, input logic [31:0] d, input logic f, input logic l);
    if (idx >= log_data.size()) begin
      chk("log_missing", 32'(log_data.size()), 32'(idx + 1));
    end else begin
      chk("lit_data", log_data[idx], d);
      chk("lit_first", 32'(log_first[idx]), 32'(f));
      chk("lit_last", 32'(log_last[idx]), 32'(l));
    end
  endtask

  initial begin
    do_reset();
    cycle();
    chk("rst_valid", 32'(cmd_valid_o), 32'd0);
    chk("rst_data", cmd_data_o, 32'd0);
    chk("rst_first", 32'(cmd_first_o), 32'd0);
    chk("rst_last", 32'(cmd_last_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_deq", 32'(fifo_deq_o), 32'd0);

    // Basic 3-word packet at full rate.
    do_reset();
    fifo_m = '{32'h0000_0002, 32'hAAAA_0001, 32'hBBBB_0002};
    run_until(3, 40, "t1_words");
    cycle(); cycle();
    chk("t1_busy_end", 32'(busy_o), 32'd0);
    chk("t1_deq_cnt", 32'(deq_cnt), 32'd3);
    chk_log(0, 32'h0000_0002, 1'b1, 1'b0);
    chk_log(1, 32'hAAAA_0001, 1'b0, 1'b0);
    chk_log(2, 32'hBBBB_0002, 1'b0, 1'b1);
`ifdef FIFO_CMD_READER_STATS_EN
    chk("t1_stat_words", stat_words_o, 32'd3);
    chk("t1_stat_pkts", stat_pkts_o, 32'd1);
`endif

    // Zero-length header followed by a one-payload packet.
    do_reset();
    fifo_m = '{32'h3000_0000, 32'h1000_0001, 32'h0000_0055};
    run_until(3, 40, "t2_words");
    chk_log(0, 32'h3000_0000, 1'b1, 1'b1);
    chk_log(1, 32'h1000_0001, 1'b1, 1'b0);
    chk_log(2, 32'h0000_0055, 1'b0, 1'b1);

    // Downstream backpressure toggling every cycle.
    do_reset();
    ready_toggle = 1'b1;
    rdy_phase = 1'b0;
    fifo_m = '{32'h0000_0002, 32'hAAAA_0001, 32'hBBBB_0002};
    run_until(3, 60, "t3_words");
    ready_toggle = 1'b0;
    cycle(); cycle();
    chk("t3_deq_cnt", 32'(deq_cnt), 32'd3);
    chk("t3_no_dup", 32'(hs_cnt), 32'd3);
    chk_log(2, 32'hBBBB_0002, 1'b0, 1'b1);
`ifdef FIFO_CMD_READER_STATS_EN
    chk("t3_stat_stall", stat_stall_o, 32'(stall_cnt));
    chk("t3_stat_pkts", stat_pkts_o, 32'd1);
`endif

    // FIFO runs dry mid-packet, then refills.
    do_reset();
    fifo_m = '{32'h0000_0003, 32'h0000_0011};
    run_until(2, 30, "t4_first_part");
    repeat (20) cycle();
    chk("t4_wait_valid", 32'(cmd_valid_o), 32'd0);
    chk("t4_wait_busy", 32'(busy_o), 32'd1);
    fifo_m.push_back(32'h0000_0022);
    fifo_m.push_back(32'h0000_0033);
    run_until(4, 30, "t4_rest");
    cycle();
    chk_log(3, 32'h0000_0033, 1'b0, 1'b1);
    chk("t4_busy_end", 32'(busy_o), 32'd0);

    // Reset in the middle of a packet.
    do_reset();
    fifo_m = '{32'h0000_0003, 32'h0000_00A1};
    run_until(2, 30, "t5_partial");
    chk("t5_busy_before", 32'(busy_o), 32'd1);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    chk("t5_valid", 32'(cmd_valid_o), 32'd0);
    chk("t5_data", cmd_data_o, 32'd0);
    chk("t5_first", 32'(cmd_first_o), 32'd0);
    chk("t5_last", 32'(cmd_last_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    fifo_m.push_back(32'hC0DE_0000);
    run_until(3, 30, "t5_after");
    chk_log(2, 32'hC0DE_0000, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
